// File: rtl/control_detencion_pkg.sv
`default_nettype none
// ============================================================================
// Module      : control_detencion_pkg
// Description : Shared types and constants for the pipeline interlock
//               controller (state encoding, default register-address width,
//               timeout-counter width helper).
// Revision    : 1.0 - initial release
// ============================================================================
package control_detencion_pkg;

    localparam int REG_W_DEF = 4;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // Width of the memory-wait counter; never narrower than one bit.
    function automatic int wait_cnt_w(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_detencion_if.sv
`default_nettype none
// ============================================================================
// Module      : control_detencion_if
// Description : Hazard-information inputs and stall/bubble/flush controls
//               exchanged between the pipeline datapath (master) and the
//               interlock controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface control_detencion_if
    import control_detencion_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] Ra_F_Reg;
    logic [REG_W-1:0] Rb_F_Reg;
    logic             RE_A_F_Reg;
    logic             RE_B_F_Reg;
    logic [REG_W-1:0] Robj_Reg_Exe;
    logic             WE_Reg_Exe;
    logic             mem_RE_Reg_Exe;
    logic             mem_req_Exe_Mem;
    logic             mem_ack;
    logic             branch_taken_Exe;

    logic             stall_PC;
    logic             stall_F_Reg;
    logic             stall_Reg_Exe;
    logic             stall_Exe_Mem;
    logic             bubble_Reg_Exe;
    logic             bubble_Mem_WB;
    logic             flush_F_Reg;
    logic             sel_pc_branch;
    logic             err_timeout;
    logic [CNT_W-1:0] cnt_load;
    logic [CNT_W-1:0] cnt_mem;
    logic [CNT_W-1:0] cnt_flush;

    modport master (
        output Ra_F_Reg, Rb_F_Reg, RE_A_F_Reg, RE_B_F_Reg, Robj_Reg_Exe,
               WE_Reg_Exe, mem_RE_Reg_Exe, mem_req_Exe_Mem, mem_ack,
               branch_taken_Exe,
        input  stall_PC, stall_F_Reg, stall_Reg_Exe, stall_Exe_Mem,
               bubble_Reg_Exe, bubble_Mem_WB, flush_F_Reg, sel_pc_branch,
               err_timeout, cnt_load, cnt_mem, cnt_flush
    );

    modport slave (
        input  Ra_F_Reg, Rb_F_Reg, RE_A_F_Reg, RE_B_F_Reg, Robj_Reg_Exe,
               WE_Reg_Exe, mem_RE_Reg_Exe, mem_req_Exe_Mem, mem_ack,
               branch_taken_Exe,
        output stall_PC, stall_F_Reg, stall_Reg_Exe, stall_Exe_Mem,
               bubble_Reg_Exe, bubble_Mem_WB, flush_F_Reg, sel_pc_branch,
               err_timeout, cnt_load, cnt_mem, cnt_flush
    );

endinterface
`default_nettype wire

// File: rtl/control_detencion_contador_espera.sv
`default_nettype none
// ============================================================================
// Module      : contador_espera
// Description : Memory-wait cycle counter. clr has priority over inc; done
//               flags the last permitted wait cycle (MEM_TIMEOUT-1).
// Revision    : 1.0 - initial release
// ============================================================================
module contador_espera
    import control_detencion_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr,
    input  wire logic inc,
    output logic      done
);
    localparam int W = wait_cnt_w(MEM_TIMEOUT);

    logic [W-1:0] wait_cnt_q;
    logic [W-1:0] wait_cnt_d;

    // Next count: clear on release/abort, step while the freeze continues.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clr) begin
            wait_cnt_d = '0;
        end else if (inc) begin
            wait_cnt_d = wait_cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign done = (wait_cnt_q == W'(MEM_TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/control_detencion.sv
`default_nettype none
// ============================================================================
// Module      : control_detencion
// Description : Pipeline interlock controller. Handles load-use stalls,
//               variable-latency data-memory freezes with timeout abort, and
//               taken-branch flushes. Controls are Mealy (state + inputs).
//               Optional macro DETENCION_PERF_EN builds saturating
//               performance counters; otherwise the counter ports read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module control_detencion
    import control_detencion_pkg::*;
#(
    parameter int REG_W       = REG_W_DEF,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input wire logic            clk,
    input wire logic            rst,
    control_detencion_if.slave  bus
);
    state_t state_q;
    state_t state_d;
    logic   err_timeout_q;
    logic   err_timeout_d;

    logic   wait_clr;
    logic   wait_inc;
    logic   wait_done;

    logic   freeze;     // whole front of the pipe held, MEM/WB gets a NOP
    logic   flush;      // taken branch redirects PC and squashes IF/ID, ID/EX
    logic   ldu;        // single load-use bubble

    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [REG_W-1:0] robj;
    logic             load_use;

    assign ra   = bus.Ra_F_Reg;
    assign rb   = bus.Rb_F_Reg;
    assign robj = bus.Robj_Reg_Exe;

    assign load_use = bus.WE_Reg_Exe && bus.mem_RE_Reg_Exe &&
                      ((bus.RE_A_F_Reg && (ra == robj)) ||
                       (bus.RE_B_F_Reg && (rb == robj)));

    contador_espera #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_contador_espera (
        .clk  (clk),
        .rst  (rst),
        .clr  (wait_clr),
        .inc  (wait_inc),
        .done (wait_done)
    );

    // Hazard arbitration and next-state logic; everything is quiet under rst.
    always_comb begin
        state_d       = state_q;
        err_timeout_d = err_timeout_q;
        wait_clr      = 1'b0;
        wait_inc      = 1'b0;
        freeze        = 1'b0;
        flush         = 1'b0;
        ldu           = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.mem_req_Exe_Mem && !bus.mem_ack) begin
                    // Counter is always 0 in RUN, so one step loads 1.
                    freeze   = 1'b1;
                    wait_inc = 1'b1;
                    state_d  = MEM_WAIT;
                end else if (bus.branch_taken_Exe) begin
                    flush = 1'b1;
                end else if (load_use) begin
                    ldu = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Branch/load-use are re-presented by the frozen EXE stage
                // after release, so they are not remembered here.
                if (bus.mem_ack) begin
                    state_d  = RUN;
                    wait_clr = 1'b1;
                end else if (wait_done) begin
                    err_timeout_d = 1'b1;
                    state_d       = RUN;
                    wait_clr      = 1'b1;
                end else begin
                    freeze   = 1'b1;
                    wait_inc = 1'b1;
                end
            end
            default: begin
                state_d  = RUN;
                wait_clr = 1'b1;
            end
        endcase
        if (rst) begin
            freeze = 1'b0;
            flush  = 1'b0;
            ldu    = 1'b0;
        end
    end

    // State and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign bus.stall_PC       = freeze | ldu;
    assign bus.stall_F_Reg    = freeze | ldu;
    assign bus.stall_Reg_Exe  = freeze;
    assign bus.stall_Exe_Mem  = freeze;
    assign bus.bubble_Mem_WB  = freeze;
    assign bus.bubble_Reg_Exe = flush | ldu;
    assign bus.flush_F_Reg    = flush;
    assign bus.sel_pc_branch  = flush;
    assign bus.err_timeout    = err_timeout_q;

`ifdef DETENCION_PERF_EN
    logic [CNT_W-1:0] cnt_load_q,  cnt_load_d;
    logic [CNT_W-1:0] cnt_mem_q,   cnt_mem_d;
    logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;

    // Saturating event counters.
    always_comb begin
        cnt_load_d  = cnt_load_q;
        cnt_mem_d   = cnt_mem_q;
        cnt_flush_d = cnt_flush_q;
        if (ldu && !(&cnt_load_q)) begin
            cnt_load_d = cnt_load_q + CNT_W'(1);
        end
        if (freeze && !(&cnt_mem_q)) begin
            cnt_mem_d = cnt_mem_q + CNT_W'(1);
        end
        if (flush && !(&cnt_flush_q)) begin
            cnt_flush_d = cnt_flush_q + CNT_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_load_q  <= '0;
            cnt_mem_q   <= '0;
            cnt_flush_q <= '0;
        end else begin
            cnt_load_q  <= cnt_load_d;
            cnt_mem_q   <= cnt_mem_d;
            cnt_flush_q <= cnt_flush_d;
        end
    end

    assign bus.cnt_load  = cnt_load_q;
    assign bus.cnt_mem   = cnt_mem_q;
    assign bus.cnt_flush = cnt_flush_q;
`else
    assign bus.cnt_load  = {CNT_W{1'b0}};
    assign bus.cnt_mem   = {CNT_W{1'b0}};
    assign bus.cnt_flush = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_control_detencion.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_detencion
// Description : Directed self-checking bench for control_detencion
//               (MEM_TIMEOUT=4, CNT_W=2). Counter expectations follow
//               DETENCION_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_detencion;

    localparam int REG_W       = 4;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 2;

    // Control vector order: stall_PC, stall_F_Reg, stall_Reg_Exe,
    // stall_Exe_Mem, bubble_Reg_Exe, bubble_Mem_WB, flush_F_Reg, sel_pc_branch
    localparam logic [7:0] C_NONE   = 8'b0000_0000;
    localparam logic [7:0] C_FREEZE = 8'b1111_0100;
    localparam logic [7:0] C_LDU    = 8'b1100_1000;
    localparam logic [7:0] C_BR     = 8'b0000_1011;

    logic clk;
    logic rst;

    control_detencion_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    control_detencion #(
        .REG_W       (REG_W),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_load   = 0;
    int n_mem    = 0;
    int n_flush  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef DETENCION_PERF_EN
        return (n > 3) ? 32'd3 : 32'(n);
`else
        return (n > 3) ? 32'd0 : 32'd0 & 32'(n);
`endif
    endfunction

    function automatic logic [7:0] ctl();
        return {bus.stall_PC, bus.stall_F_Reg, bus.stall_Reg_Exe,
                bus.stall_Exe_Mem, bus.bubble_Reg_Exe, bus.bubble_Mem_WB,
                bus.flush_F_Reg, bus.sel_pc_branch};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctl(input string tag, input logic [7:0] exp);
        #1;
        check_eq(tag, {24'd0, ctl()}, {24'd0, exp});
    endtask

    task automatic check_cnts(input string tag);
        check_eq({tag, "_cnt_load"},  {30'd0, bus.cnt_load},  exp_cnt(n_load));
        check_eq({tag, "_cnt_mem"},   {30'd0, bus.cnt_mem},   exp_cnt(n_mem));
        check_eq({tag, "_cnt_flush"}, {30'd0, bus.cnt_flush}, exp_cnt(n_flush));
    endtask

    task automatic clear_in();
        bus.Ra_F_Reg         = '0;
        bus.Rb_F_Reg         = '0;
        bus.RE_A_F_Reg       = 1'b0;
        bus.RE_B_F_Reg       = 1'b0;
        bus.Robj_Reg_Exe     = '0;
        bus.WE_Reg_Exe       = 1'b0;
        bus.mem_RE_Reg_Exe   = 1'b0;
        bus.mem_req_Exe_Mem  = 1'b0;
        bus.mem_ack          = 1'b0;
        bus.branch_taken_Exe = 1'b0;
    endtask

    task automatic set_load(input logic [3:0] robj);
        bus.Robj_Reg_Exe   = robj;
        bus.WE_Reg_Exe     = 1'b1;
        bus.mem_RE_Reg_Exe = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        // Hazard present while in reset: controls must stay low.
        bus.mem_req_Exe_Mem  = 1'b1;
        bus.branch_taken_Exe = 1'b1;
        check_ctl("rst_forces_zero", C_NONE);
        step();
        step();
        rst = 1'b0;
        clear_in();
        check_ctl("post_rst_idle", C_NONE);
        check_eq("post_rst_err", {31'd0, bus.err_timeout}, 32'd0);
        check_cnts("post_rst");

        // Load-use on Ra: exactly one bubble, then the load has moved on.
        set_load(4'd3);
        bus.Ra_F_Reg = 4'd3; bus.RE_A_F_Reg = 1'b1;
        check_ctl("ldu_ra", C_LDU);
        n_load++;
        step();
        bus.WE_Reg_Exe = 1'b0; bus.mem_RE_Reg_Exe = 1'b0;
        check_ctl("ldu_ra_after", C_NONE);
        step();
        // Same registers but Ra not read.
        set_load(4'd3);
        bus.RE_A_F_Reg = 1'b0;
        check_ctl("ldu_ra_not_read", C_NONE);
        // Match through Rb.
        bus.Rb_F_Reg = 4'd3; bus.RE_B_F_Reg = 1'b1;
        check_ctl("ldu_rb", C_LDU);
        n_load++;
        step();
        // Non-load producer: forwarding covers it.
        bus.mem_RE_Reg_Exe = 1'b0;
        check_ctl("alu_no_stall", C_NONE);
        // Different destination register.
        bus.mem_RE_Reg_Exe = 1'b1; bus.Robj_Reg_Exe = 4'd5;
        check_ctl("ldu_no_match", C_NONE);
        step();
        // Register 0 is not special.
        clear_in();
        set_load(4'd0);
        bus.RE_A_F_Reg = 1'b1;
        check_ctl("ldu_r0", C_LDU);
        n_load++;
        step();
        // Branch and load-use together: branch wins.
        bus.branch_taken_Exe = 1'b1;
        check_ctl("br_over_ldu", C_BR);
        n_flush++;
        step();
        clear_in();
        check_cnts("after_ldu");

        // Memory wait released by ack three cycles later; branch ignored
        // during the wait and honoured after release.
        bus.mem_req_Exe_Mem = 1'b1;
        check_ctl("mw_c0", C_FREEZE);
        n_mem++;
        step();
        check_ctl("mw_c1", C_FREEZE);
        n_mem++;
        step();
        bus.branch_taken_Exe = 1'b1;
        check_ctl("mw_c2_branch_ignored", C_FREEZE);
        n_mem++;
        step();
        bus.mem_ack = 1'b1;
        check_ctl("mw_ack_release", C_NONE);
        step();
        bus.mem_req_Exe_Mem = 1'b0; bus.mem_ack = 1'b0;
        check_ctl("mw_branch_after", C_BR);
        n_flush++;
        step();
        clear_in();
        check_eq("mw_err", {31'd0, bus.err_timeout}, 32'd0);
        check_cnts("after_mw");

        // Ack in the same cycle as the request: no stall, stay in RUN.
        bus.mem_req_Exe_Mem = 1'b1; bus.mem_ack = 1'b1;
        check_ctl("ack_same_cycle", C_NONE);
        step();
        clear_in();
        bus.branch_taken_Exe = 1'b1;
        check_ctl("ack_same_still_run", C_BR);
        n_flush++;
        step();
        clear_in();

        // Timeout: three freeze cycles, released in the fourth.
        bus.mem_req_Exe_Mem = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_ctl($sformatf("to_freeze_%0d", i), C_FREEZE);
            n_mem++;
            step();
        end
        check_ctl("to_release", C_NONE);
        check_eq("to_err_not_yet", {31'd0, bus.err_timeout}, 32'd0);
        step();
        bus.mem_req_Exe_Mem = 1'b0;
        check_eq("to_err_set", {31'd0, bus.err_timeout}, 32'd1);
        bus.branch_taken_Exe = 1'b1;
        check_ctl("to_back_in_run", C_BR);
        n_flush++;
        step();
        clear_in();
        step();
        check_eq("to_err_sticky", {31'd0, bus.err_timeout}, 32'd1);
        check_cnts("after_to");

        // Reset in the middle of a memory wait.
        bus.mem_req_Exe_Mem = 1'b1;
        check_ctl("rstmw_c0", C_FREEZE);
        step();
        check_ctl("rstmw_c1", C_FREEZE);
        rst = 1'b1;
        check_ctl("rstmw_rst_zero", C_NONE);
        step();
        rst = 1'b0;
        clear_in();
        n_load = 0; n_mem = 0; n_flush = 0;
        check_ctl("rstmw_idle", C_NONE);
        check_eq("rstmw_err_clr", {31'd0, bus.err_timeout}, 32'd0);
        check_cnts("rstmw");
        bus.branch_taken_Exe = 1'b1;
        check_ctl("rstmw_in_run", C_BR);
        n_flush++;
        step();

        // Five flushes saturate a 2-bit counter.
        for (int i = 0; i < 4; i++) begin
            check_ctl($sformatf("sat_br_%0d", i), C_BR);
            n_flush++;
            step();
        end
        clear_in();
        check_eq("sat_flush", {30'd0, bus.cnt_flush}, exp_cnt(n_flush));
        check_cnts("final");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_detencion.md
# control_detencion

Pipeline interlock controller for the 5-stage filter processor. It complements the forwarding unit by covering the hazards forwarding cannot resolve: load-use dependencies, variable-latency data-memory accesses, and taken branches resolved in EXE. It drives the stall/hold enables of PC and the pipeline registers, and the bubble/flush controls that insert NOPs. It also enforces a memory-wait timeout.

## Interface
Parameters:
- REG_W, 4, register-address width
- MEM_TIMEOUT, 64, maximum cycles spent in MEM_WAIT before abort (≥2)
- CNT_W, 16, performance-counter width (used only with DETENCION_PERF_EN)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- Ra_F_Reg, Rb_F_Reg  in  REG_W  source registers of the instruction in IF/ID
- RE_A_F_Reg, RE_B_F_Reg  in  1  that instruction actually reads Ra / Rb
- Robj_Reg_Exe  in  REG_W  destination of the instruction in ID/EX
- WE_Reg_Exe  in  1  ID/EX instruction writes Robj
- mem_RE_Reg_Exe  in  1  ID/EX instruction is a load
- mem_req_Exe_Mem  in  1  EX/MEM instruction accesses data memory this cycle
- mem_ack  in  1  data memory completes the access this cycle
- branch_taken_Exe  in  1  branch in EXE resolved taken
- stall_PC, stall_F_Reg, stall_Reg_Exe, stall_Exe_Mem  out  1 each  hold the register
- bubble_Reg_Exe, bubble_Mem_WB  out  1 each  load NOP into ID/EX / MEM/WB
- flush_F_Reg  out  1  load NOP into IF/ID
- sel_pc_branch  out  1  PC loads branch target
- err_timeout  out  1  sticky memory-timeout flag
- cnt_load, cnt_mem, cnt_flush  out  CNT_W each  performance counters

## Operation
- FSM states: RUN, MEM_WAIT. Counter wait_cnt (clog2(MEM_TIMEOUT) bits). Outputs are Mealy: they depend on the current state and current inputs.
- **RUN**, evaluated by priority (highest first):
  1. **Memory wait.** Condition: mem_req_Exe_Mem && !mem_ack.
     - Assert stall_PC, stall_F_Reg, stall_Reg_Exe, stall_Exe_Mem and bubble_Mem_WB.
     - Next state MEM_WAIT, wait_cnt←1.
  2. **Taken branch.** Condition: branch_taken_Exe.
     - Assert sel_pc_branch, flush_F_Reg, bubble_Reg_Exe.
  3. **Load-use.** Condition: WE_Reg_Exe && mem_RE_Reg_Exe && ((RE_A_F_Reg && Ra_F_Reg==Robj_Reg_Exe) || (RE_B_F_Reg && Rb_F_Reg==Robj_Reg_Exe)).
     - Assert stall_PC, stall_F_Reg, bubble_Reg_Exe. This inserts exactly one bubble; the later WB forwarding covers the rest.
     - Register 0 is not special-cased.
  4. Otherwise all controls are 0.
- **MEM_WAIT:**
  - mem_ack=1: all controls 0 (the access completes and the pipeline advances this cycle); next state RUN; wait_cnt←0.
  - mem_ack=0 and wait_cnt==MEM_TIMEOUT-1:
    - Timeout. Set err_timeout. All controls 0; the instruction is abandoned.
    - Next state RUN; wait_cnt←0.
  - Otherwise: same freeze set as RUN case 1; wait_cnt+1.
  - branch_taken_Exe and the load-use condition are ignored here. The frozen EXE instruction re-presents them after release, so no pending flag is kept.
- err_timeout is cleared only by rst.

## Timing
- All outputs are combinational from state and inputs, with zero-cycle latency. They must settle within the same cycle as the hazard.
- Reset value while rst=1, and at the first edge after it: state RUN, wait_cnt 0, err_timeout 0, counters 0. All control outputs are forced to 0 while rst=1.
- rst asserted mid-MEM_WAIT returns to RUN on that edge; no ack is awaited.
- mem_ack asserted in the same cycle as mem_req (RUN): no stall, zero extra cycles.
- Simultaneous branch and load-use: the branch wins; the dependent instruction is flushed.
- Simultaneous memory wait and branch: the memory wait wins; the branch takes effect in the cycle after release.

## Configuration
- DETENCION_PERF_EN defined: the three saturating counters are implemented.
  - cnt_load increments on each load-use stall cycle.
  - cnt_mem increments on each freeze cycle.
  - cnt_flush increments on each taken-branch flush.
  - Each counter stops at 2^CNT_W−1 and is reset by rst.
- DETENCION_PERF_EN undefined: the ports remain present and are tied to 0, and no counter logic is built.

## Structure
- Shared package control_detencion_pkg holds the state encoding (RUN=1'b0, MEM_WAIT=1'b1) and the default REG_W.
- Sub-module contador_espera holds the timeout counter, with ports clk, rst, clr, inc, and a done output.

## Test plan
- Load-use: load R3 in ID/EX, Ra_F_Reg=3, RE_A_F_Reg=1 → exactly 1 cycle of stall_PC=stall_F_Reg=bubble_Reg_Exe=1; the same case with RE_A_F_Reg=0 → no stall.
- Memory wait: mem_req with mem_ack arriving 3 cycles later → freeze asserted for 3 cycles and released in the ack cycle; cnt_mem=3 with DETENCION_PERF_EN.
- Timeout: MEM_TIMEOUT=4, mem_ack held at 0 → freeze for 3 cycles, controls released in cycle 4, err_timeout=1 sticky until rst.
- Priority: branch_taken_Exe and load-use in the same cycle → sel_pc_branch=flush_F_Reg=bubble_Reg_Exe=1 and stall_PC=0; a branch during MEM_WAIT takes effect only after release.
- Reset: rst pulsed during MEM_WAIT → the next cycle is in RUN with all outputs 0 and counters 0.
- Counter saturation: with CNT_W=2, five flushes → cnt_flush=3.
